// File: rtl/mini_src_pkg.sv
// Shared definitions for the mini SRC control slice.
//   state_t        : sequencer states IDLE, T0..T6
//   OP_*           : opcode constants decoded from ir[31:27]
//   *_MSB / *_LSB  : ir field bit positions (opcode, ra, rb, rc)
//   ALU_PC_INC     : ALU_Control code used for the PC increment in T0
//   is_* helpers   : opcode classification used by the sequencer
// Optional feature macro: MULDIV_EN (makes MUL/DIV legal opcodes).
package mini_src_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6
  } state_t;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SHL = 5'b00100;
  localparam logic [4:0] OP_NOT = 5'b00101;
  localparam logic [4:0] OP_NEG = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_ROR = 5'b01001;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned RC_LSB  = 15;

  localparam logic [4:0] ALU_PC_INC = 5'b00000;

  function automatic logic is_binary(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NOT) || (op == OP_NEG);
  endfunction

  // Constant 0 when the multiply/divide unit is not built, which makes
  // T6 unreachable without any further guarding in the sequencer.
  function automatic logic is_muldiv(input logic [4:0] op);
`ifdef MULDIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op != op);
`endif
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return is_binary(op) || is_unary(op) || is_muldiv(op);
  endfunction

endpackage

// File: rtl/reg_decoder.sv
// One-hot register select decoder.
//   index  : 4-bit register number R0..R15
//   enable : when low, the output vector is all zero
//   onehot : 16-bit vector with bit [index] set when enabled
module reg_decoder (
  input  logic [3:0]  index,
  input  logic        enable,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (enable) onehot[index] = 1'b1;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute control sequencer for the mini SRC datapath.
// Ports:
//   clock, clear        : rising-edge clock, synchronous active-high reset
//   start               : request one instruction (sampled only in IDLE)
//   ir[31:0]            : instruction register from the datapath
//   Rin, Rout[15:0]     : one-hot register load / bus-drive enables
//   PCout..LOin         : datapath strobes
//   ALU_Control[4:0]    : ALU operation select
//   busy                : high whenever not in IDLE
//   done, illegal       : one-cycle completion / bad-opcode pulses
// Optional feature macro: MULDIV_EN (MUL/DIV with a T6 HI-write cycle).
// Without it HIin, LOin and Zhighout are tied low.
module alu_sequencer
  import mini_src_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  ALU_Control,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  state_t      state;
  state_t      state_nxt;

  logic [4:0]  opcode;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic        legal_op;
  logic        unary_op;
  logic        muldiv_op;

  logic        rin_en;
  logic        rout_en;
  logic [3:0]  rout_idx;

  // Low ir bits carry immediates/unused fields that this sequencer ignores.
  logic        unused_ir_bits;
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  assign opcode    = ir[OPC_MSB:OPC_LSB];
  assign ra        = ir[RA_MSB:RA_LSB];
  assign rb        = ir[RB_MSB:RB_LSB];
  assign rc        = ir[RC_MSB:RC_LSB];
  assign legal_op  = is_legal(opcode);
  assign unary_op  = is_unary(opcode);
  assign muldiv_op = is_muldiv(opcode);

  // State register plus the two pulse flops.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= ((state == S_T5) && !muldiv_op) || (state == S_T6);
      illegal <= (state == S_T3) && !legal_op;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = legal_op ? S_T4 : S_IDLE;
      S_T4:    state_nxt = S_T5;
      S_T5:    state_nxt = muldiv_op ? S_T6 : S_IDLE;
      S_T6:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    PCout       = 1'b0;
    PCin        = 1'b0;
    IncPC       = 1'b0;
    MARin       = 1'b0;
    Read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    Zlowout     = 1'b0;
`ifdef MULDIV_EN
    Zhighout    = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
`endif
    ALU_Control = '0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_idx    = rb;
    busy        = (state != S_IDLE);
    case (state)
      S_T0: begin
        PCout       = 1'b1;
        MARin       = 1'b1;
        IncPC       = 1'b1;
        Zin         = 1'b1;
        ALU_Control = ALU_PC_INC;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (legal_op) begin
          rout_en  = 1'b1;
          rout_idx = rb;
          Yin      = 1'b1;
        end
      end
      S_T4: begin
        // Only legal opcodes reach T4; every non-unary op reads rc.
        Zin         = 1'b1;
        ALU_Control = opcode;
        if (!unary_op) begin
          rout_en  = 1'b1;
          rout_idx = rc;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
`ifdef MULDIV_EN
        if (muldiv_op) LOin   = 1'b1;
        else           rin_en = 1'b1;
`else
        rin_en = 1'b1;
`endif
      end
`ifdef MULDIV_EN
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

`ifndef MULDIV_EN
  assign Zhighout = 1'b0;
  assign HIin     = 1'b0;
  assign LOin     = 1'b0;
`endif

  reg_decoder u_rin_dec (
    .index  (ra),
    .enable (rin_en),
    .onehot (Rin)
  );

  reg_decoder u_rout_dec (
    .index  (rout_idx),
    .enable (rout_en),
    .onehot (Rout)
  );

endmodule
